// File: rtl/telemetry_scheduler.sv
// telemetry_scheduler
//   Rate-driven scheduler/arbiter sharing one telemetry_serialize link among
//   NUM_SRC packet sources in the 128 MHz transmit domain. Each source has a
//   period timer. On expiry the source is marked pending. Pending sources are
//   granted round-robin: trigger, capture the returned packet, and hand it to
//   the serializer when it is ready.
//
//   Optional feature macro: TELEM_SCHED_TIMEOUT_EN
//     defined   - WAIT gives up after TIMEOUT cycles and counts in timeout_count
//     undefined - WAIT waits forever and timeout_count is tied to 0
//
// Ports
//   clk              transmit clock
//   reset_clk        synchronous active-high reset
//   enable           scheduler enable (in-flight transaction always completes)
//   rate             per-source period, RATE_W bits each; 0 disables a source
//   src_trigger      one-cycle one-hot request to the granted source
//   src_data         packet bus from each source, PKT_W bits each
//   src_valid        per-source data-valid strobe
//   packet           packet to serializer, held between strobes
//   packet_valid     one-cycle strobe to serializer
//   serializer_ready serializer can accept a packet
//   busy             FSM not in IDLE
//   overrun_count    saturating count of periods lost to a still-pending source
//   timeout_count    saturating count of timed-out requests

// Per-source period timer: counts rate-1 .. 0 and ticks on 0.
module telemetry_sched_timer #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset_clk,
  input  logic              act,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);
  logic [RATE_W-1:0] cnt, reload;

  assign reload = (rate == '0) ? '0 : rate - RATE_W'(1);
  assign tick   = act && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset_clk || !act || cnt == '0) cnt <= reload;
    else                                cnt <= cnt - RATE_W'(1);
  end
endmodule

module telemetry_scheduler #(
  parameter int NUM_SRC = 2,
  parameter int PKT_W   = 88,
  parameter int RATE_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_clk,
  input  logic                      enable,
  input  logic [NUM_SRC*RATE_W-1:0] rate,
  output logic [NUM_SRC-1:0]        src_trigger,
  input  logic [NUM_SRC*PKT_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [PKT_W-1:0]          packet,
  output logic                      packet_valid,
  input  logic                      serializer_ready,
  output logic                      busy,
  output logic [15:0]               overrun_count,
  output logic [15:0]               timeout_count
);
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, SEND} state_t;
  state_t state, state_nxt;

  logic [NUM_SRC-1:0]            act, tick, pending, clr, ovr_bits;
  logic [NUM_SRC-1:0][PKT_W-1:0] data_arr;
  logic [GW-1:0]                 grant, sel, cand;
  logic [PKT_W-1:0]              hold;
  logic [16:0]                   ovr_sum;
  logic                          go, tmo;
  int                            idx;

  assign data_arr = src_data;

  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_lane
      assign act[i] = enable && (rate[i*RATE_W +: RATE_W] != '0);
      telemetry_sched_timer #(.RATE_W(RATE_W)) u_tmr (
        .clk      (clk),
        .reset_clk(reset_clk),
        .act      (act[i]),
        .rate     (rate[i*RATE_W +: RATE_W]),
        .tick     (tick[i])
      );
    end
  endgenerate

  // Round-robin pick. grant doubles as the last-grant pointer; scanning from
  // the farthest candidate down means the nearest pending source wins.
  always_comb begin
    sel  = grant;
    cand = '0;
    idx  = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx  = (int'(grant) + k) % NUM_SRC;
      cand = GW'(idx);
      if (pending[cand]) sel = cand;
    end
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      IDLE: if (enable && pending != '0) begin
              go        = 1'b1;
              state_nxt = TRIG;
            end
      TRIG: state_nxt = WAIT;
      WAIT: if (src_valid[grant]) state_nxt = SEND;
            else if (tmo)         state_nxt = IDLE;
      SEND: if (serializer_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr         = go ? (NUM_SRC'(1) << sel) : '0;
  // An expiry coinciding with the grant's clear re-arms the source, no overrun.
  assign ovr_bits    = tick & pending & ~clr;
  assign ovr_sum     = {1'b0, overrun_count} + 17'($countones(ovr_bits));
  assign src_trigger = (state == TRIG) ? (NUM_SRC'(1) << grant) : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state         <= IDLE;
      grant         <= GW'(NUM_SRC - 1);
      pending       <= '0;
      hold          <= '0;
      packet        <= '0;
      packet_valid  <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_nxt;
      packet_valid  <= 1'b0;
      pending       <= ((pending & ~clr) | tick) & act;
      overrun_count <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
      if (go) grant <= sel;
      if (state == WAIT && src_valid[grant]) hold <= data_arr[grant];
      if (state == SEND && serializer_ready) begin
        packet       <= hold;
        packet_valid <= 1'b1;
      end
    end
  end

`ifdef TELEM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign tmo = (wait_cnt == TW'(TIMEOUT));

  // wait_cnt reads 1 in the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset_clk) begin
      wait_cnt      <= '0;
      timeout_count <= '0;
    end else begin
      if (state == TRIG)      wait_cnt <= TW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
      if (state == WAIT && !src_valid[grant] && tmo && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end
`else
  assign tmo           = 1'b0;
  assign timeout_count = '0;
`endif
endmodule

// File: tb/tb_telemetry_scheduler.sv
module tb_telemetry_scheduler;
  localparam int NS = 2;
  localparam int PW = 88;
  localparam int RW = 16;
  localparam logic [PW-1:0] D0  = 88'hA5_0000_0000_0000_0000_0001;
  localparam logic [PW-1:0] D1  = 88'h5A_1111_2222_3333_4444_0002;
  localparam logic [PW-1:0] BAD = 88'hDE_AD00_0000_0000_0000_00BE;

  logic             clk = 1'b0;
  logic             reset_clk = 1'b0;
  logic             enable = 1'b0;
  logic [NS*RW-1:0] rate = '0;
  logic [NS-1:0]    src_trigger;
  logic [PW-1:0]    d0 = D0, d1 = D1;
  logic [NS*PW-1:0] src_data;
  logic [NS-1:0]    src_valid, vld_m = '0, stray = '0, respond = '0;
  logic [PW-1:0]    packet;
  logic             packet_valid;
  logic             serializer_ready = 1'b0;
  logic             busy;
  logic [15:0]      overrun_count, timeout_count;

  int nvec = 0, nerr = 0, cyc = 0;
  int dly[NS];
  int cd[NS];
  logic [NS-1:0] trig_q[$];
  int            trig_cyc_q[$];
  logic [PW-1:0] pv_q[$];
  int            pv_cyc_q[$];

  assign src_data  = {d1, d0};
  assign src_valid = vld_m | stray;

  telemetry_scheduler #(.NUM_SRC(NS), .PKT_W(PW), .RATE_W(RW), .TIMEOUT(255)) dut (
    .clk(clk), .reset_clk(reset_clk), .enable(enable), .rate(rate),
    .src_trigger(src_trigger), .src_data(src_data), .src_valid(src_valid),
    .packet(packet), .packet_valid(packet_valid),
    .serializer_ready(serializer_ready), .busy(busy),
    .overrun_count(overrun_count), .timeout_count(timeout_count)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus source models: a source answers dly cycles after its trigger.
  always @(negedge clk) begin
    if (src_trigger != '0) begin trig_q.push_back(src_trigger); trig_cyc_q.push_back(cyc); end
    if (packet_valid) begin pv_q.push_back(packet); pv_cyc_q.push_back(cyc); end
    for (int i = 0; i < NS; i++) begin
      vld_m[i] = 1'b0;
      if (reset_clk) cd[i] = 0;
      else if (cd[i] != 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) vld_m[i] = 1'b1;
      end
      if (src_trigger[i] && respond[i]) cd[i] = dly[i];
    end
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_clk = 1'b1;
    repeat (2) @(negedge clk);
    reset_clk = 1'b0;
    trig_q.delete(); trig_cyc_q.delete(); pv_q.delete(); pv_cyc_q.delete();
  endtask

  task automatic wait_trig(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (src_trigger != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pv(input int n, input int lim);
    for (int k = 0; k < lim && pv_q.size() < n; k++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, rc;
    dly[0] = 1; dly[1] = 1;

    // Single source, period 100; then reset while in WAIT
    rate = {16'd0, 16'd100}; respond = 2'b01; serializer_ready = 1'b1; enable = 1'b1;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_pv", packet_valid, 0);
    chk("rst_trig", src_trigger, 0);
    chk("rst_packet", packet, 0);
    chk("rst_ovr", overrun_count, 0);
    chk("rst_tmo", timeout_count, 0);
    wait_pv(3, 400);
    chk("s1_pv_cnt", pv_q.size(), 3);
    if (pv_q.size() >= 3) begin
      chk("s1_data0", pv_q[0], D0);
      chk("s1_data2", pv_q[2], D0);
      chk("s1_period_a", pv_cyc_q[1] - pv_cyc_q[0], 100);
      chk("s1_period_b", pv_cyc_q[2] - pv_cyc_q[1], 100);
      chk("s1_trig_cnt", trig_q.size(), 3);
      chk("s1_trig_lat", pv_cyc_q[0] - trig_cyc_q[0], 3);
      for (int k = 0; k < trig_q.size(); k++) chk("s1_trig_src", trig_q[k], 2'b01);
    end
    respond = 2'b00;
    wait_trig(120, ok);
    chk("s1_trig_seen", ok, 1);
    repeat (2) @(negedge clk);
    chk("s1_wait_busy", busy, 1);
    chk("s1_packet_held", packet, D0);
    reset_clk = 1'b1;
    @(negedge clk);
    chk("wrst_busy", busy, 0);
    chk("wrst_packet", packet, 0);
    chk("wrst_trig", src_trigger, 0);
    chk("wrst_pv", packet_valid, 0);
    reset_clk = 1'b0;

    // Round-robin with aligned timers
    rate = {16'd50, 16'd50}; respond = 2'b11;
    do_reset();
    wait_pv(6, 400);
    chk("rr_pv_cnt", pv_q.size(), 6);
    if (pv_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("rr_trig_src", trig_q[k], (k % 2) ? 2'b10 : 2'b01);
        chk("rr_data", pv_q[k], (k % 2) ? D1 : D0);
      end
      chk("rr_b2b_spacing", pv_cyc_q[1] - pv_cyc_q[0], 4);
    end
    chk("rr_ovr", overrun_count, 0);

    // Stray valids: source 0 in TRIG cycle, source 1 during WAIT
    rate = {16'd0, 16'd30}; respond = 2'b01; dly[0] = 6;
    do_reset();
    wait_trig(60, ok);
    chk("sv_trig_seen", ok, 1);
    c = cyc;
    stray = 2'b01; d0 = BAD;
    @(negedge clk); stray = 2'b00; d0 = D0;
    @(negedge clk); stray = 2'b10;
    @(negedge clk); stray = 2'b00;
    wait_pv(1, 20);
    chk("sv_pv_cnt", pv_q.size(), 1);
    if (pv_q.size() >= 1) begin
      chk("sv_data", pv_q[0], D0);
      chk("sv_lat", pv_cyc_q[0] - c, 8);
    end
    dly[0] = 1;

    // Backpressure/overrun, then enable dropped while in SEND
    rate = {16'd10, 16'd0}; respond = 2'b10; serializer_ready = 1'b0; enable = 1'b1;
    do_reset();
    wait_trig(30, ok);
    chk("bp_trig_seen", ok, 1);
    repeat (40) @(negedge clk);
    chk("bp_ovr", overrun_count, 3);
    chk("bp_pv_none", pv_q.size(), 0);
    chk("bp_trig_one", trig_q.size(), 1);
    chk("bp_busy", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    serializer_ready = 1'b1; rc = cyc;
    wait_pv(1, 3);
    chk("bp_pv_cnt", pv_q.size(), 1);
    if (pv_q.size() >= 1) begin
      chk("bp_data", pv_q[0], D1);
      chk("bp_pv_lat", ((pv_cyc_q[0] - rc) >= 1) && ((pv_cyc_q[0] - rc) <= 2), 1);
    end
    repeat (40) @(negedge clk);
    chk("en_trig_cnt", trig_q.size(), 1);
    chk("en_pv_cnt", pv_q.size(), 1);
    chk("en_busy", busy, 0);
    chk("en_ovr", overrun_count, 3);

    // Source that never answers
    rate = {16'd0, 16'd20}; respond = 2'b00; enable = 1'b1;
    do_reset();
    wait_trig(40, ok);
    chk("to_trig_seen", ok, 1);
    c = cyc;
`ifdef TELEM_SCHED_TIMEOUT_EN
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
    chk("to_idle", busy, 0);
    chk("to_when", ((cyc - c) >= 255) && ((cyc - c) <= 256), 1);
    chk("to_count", timeout_count, 1);
    chk("to_pv", pv_q.size(), 0);
`else
    repeat (300) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_count", timeout_count, 0);
    chk("nto_pv", pv_q.size(), 0);
    chk("nto_trig_cnt", trig_q.size(), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
